alu_control_sequencer: RTL and testbench

//  Hardwired control unit for the bus datapath. It replaces bench-driven control with an FSM that steps

---
 rtl/alu_control_sequencer_pkg.sv | 34 +++
 rtl/alu_control_sequencer_reg_field_decoder.sv | 10 +
 rtl/alu_control_sequencer.sv | 103 ++++++++++
 tb/tb_alu_control_sequencer.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/alu_control_sequencer_pkg.sv
// alu_control_sequencer_pkg: state encodings, opcode constants and decode helpers shared with the ALU
package alu_control_sequencer_pkg;
   localparam int NREG = 16;
   localparam int OPW  = 5;
   typedef enum logic [3:0] {
      S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
   } state_t;
   localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
   localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
   localparam logic [OPW-1:0] OP_SHR  = 5'b00101;
   localparam logic [OPW-1:0] OP_SHL  = 5'b00110;
   localparam logic [OPW-1:0] OP_ROR  = 5'b00111;
   localparam logic [OPW-1:0] OP_ROL  = 5'b01000;
   localparam logic [OPW-1:0] OP_AND  = 5'b01011;
   localparam logic [OPW-1:0] OP_OR   = 5'b01100;
   localparam logic [OPW-1:0] OP_MUL  = 5'b01111;
   localparam logic [OPW-1:0] OP_DIV  = 5'b10000;
   localparam logic [OPW-1:0] OP_NEG  = 5'b10001;
   localparam logic [OPW-1:0] OP_NOT  = 5'b10010;
   localparam logic [OPW-1:0] OP_HALT = 5'b11011;
   function automatic logic op_muldiv(input logic [OPW-1:0] op);
      return op == OP_MUL || op == OP_DIV;
   endfunction
   function automatic logic op_unary(input logic [OPW-1:0] op);
      return op == OP_NEG || op == OP_NOT;
   endfunction
   function automatic logic op_defined(input logic [OPW-1:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_AND, OP_OR,
         OP_MUL, OP_DIV, OP_NEG, OP_NOT, OP_HALT: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction
endpackage

// File: rtl/alu_control_sequencer_reg_field_decoder.sv
// reg_field_decoder: 4-bit register field to one-hot GPR select, all-zero when disabled
module reg_field_decoder #(
   parameter int N = 16
) (
   input  logic [3:0]   field,
   input  logic         en,
   output logic [N-1:0] onehot
);
   assign onehot = en ? N'(1) << field : '0;
endmodule

// File: rtl/alu_control_sequencer.sv
// alu_control_sequencer: hardwired fetch/execute FSM driving the bus datapath strobes for R-format ALU ops
module alu_control_sequencer
   import alu_control_sequencer_pkg::*;
(
   input  logic            clock,
   input  logic            clear,
   input  logic            run,
   input  logic            mem_ready,
   input  logic [31:0]     IR,
   output logic            PCout,
   output logic            ZLOout,
   output logic            ZHIout,
   output logic            MDRout,
   output logic            MARin,
   output logic            PCin,
   output logic            MDRin,
   output logic            IRin,
   output logic            Yin,
   output logic            Zlowin,
   output logic            Zhighin,
   output logic            HIin,
   output logic            LOin,
   output logic            IncPC,
   output logic            read,
   output logic [OPW-1:0]  operation,
   output logic [NREG-1:0] R_in,
   output logic [NREG-1:0] R_out,
   output logic            illegal,
   output logic            halted
);
   state_t           state, next, done;
   logic [OPW-1:0]   ir_op;
   logic [3:0]       ra, rb, rc;
   logic             defined, muldiv, unary, rout_en, rin_en, ir_unused;
   assign ir_op     = IR[31:27];
   assign ra        = IR[26:23];
   assign rb        = IR[22:19];
   assign rc        = IR[18:15];
   assign ir_unused = ^IR[14:0];
   assign defined   = op_defined(ir_op);
   assign muldiv    = op_muldiv(ir_op);
   assign unary     = op_unary(ir_op);
   assign done      = run ? S_T0 : S_IDLE;
   always_ff @(posedge clock or negedge clear)
      if (!clear) state <= S_IDLE;
      else state <= next;
   // operation is captured as IR leaves T3 so it stays stable through T4..T6
   always_ff @(posedge clock or negedge clear)
      if (!clear) operation <= '0;
      else if (state == S_T3) operation <= ir_op;
   always_comb begin
      next = state;
      unique case (state)
         S_IDLE: next = run ? S_T0 : S_IDLE;
         S_T0:   next = S_T1;
         S_T1:   next = mem_ready ? S_T2 : S_T1;
         S_T2:   next = S_T3;
         S_T3:   next = !defined ? done : ir_op == OP_HALT ? S_HALT : S_T4;
         S_T4:   next = S_T5;
         S_T5:   next = muldiv ? S_T6 : done;
         S_T6:   next = done;
         S_HALT: next = S_HALT;
         default: next = S_IDLE;
      endcase
   end
   always_comb begin
      {PCout, ZLOout, ZHIout, MDRout, MARin, PCin, MDRin, IRin, Yin} = '0;
      {Zlowin, Zhighin, HIin, LOin, IncPC, read, illegal, halted} = '0;
      {rout_en, rin_en} = '0;
      unique case (state)
         S_T0:   {PCout, MARin, IncPC, Zlowin} = '1;
         S_T1:   {ZLOout, PCin, read, MDRin} = '1;
         S_T2:   {MDRout, IRin} = '1;
         S_T3:   begin
            {Yin, rout_en} = {2{defined}};
            illegal = !defined;
         end
         S_T4:   begin
            {rout_en, Zlowin} = '1;
            Zhighin = muldiv;
         end
         S_T5:   begin
            ZLOout = 1'b1;
            LOin   = muldiv;
            rin_en = !muldiv;
         end
         S_T6:   {ZHIout, HIin} = '1;
         S_HALT: halted = 1'b1;
         default: ;
      endcase
   end
   // unary ops re-drive Rb in T4 since the ALU ignores Y for them
   reg_field_decoder #(.N(NREG)) u_rout (
      .field  ((state == S_T4 && !unary) ? rc : rb),
      .en     (rout_en),
      .onehot (R_out)
   );
   reg_field_decoder #(.N(NREG)) u_rin (
      .field  (ra),
      .en     (rin_en),
      .onehot (R_in)
   );
endmodule

// File: tb/tb_alu_control_sequencer.sv
// tb_alu_control_sequencer: per-instruction expected strobe sequences checked cycle by cycle
module tb_alu_control_sequencer;
   typedef struct packed {
      logic pc_out, zlo_out, zhi_out, mdr_out, mar_in, pc_in, mdr_in, ir_in, y_in;
      logic zlow_in, zhigh_in, hi_in, lo_in, inc_pc, rd, ill, hlt;
      logic [4:0]  op;
      logic [15:0] rin, rout;
   } obs_t;
   localparam logic [4:0] LEGAL [13] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
      5'b01000, 5'b01011, 5'b01100, 5'b01111, 5'b10000, 5'b10001, 5'b10010, 5'b11011};
   localparam logic [4:0] OP_HALT = 5'b11011;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   logic clock, clear, run, mem_ready;
   logic [31:0] IR;
   logic PCout, ZLOout, ZHIout, MDRout, MARin, PCin, MDRin, IRin, Yin;
   logic Zlowin, Zhighin, HIin, LOin, IncPC, read, illegal, halted;
   logic [4:0]  operation;
   logic [15:0] R_in, R_out;
   obs_t obs;
   logic [4:0] cur_op;
   int n_checks = 0;
   int n_fail = 0;
   alu_control_sequencer dut (
      .clock(clock), .clear(clear), .run(run), .mem_ready(mem_ready), .IR(IR),
      .PCout(PCout), .ZLOout(ZLOout), .ZHIout(ZHIout), .MDRout(MDRout),
      .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
      .Zlowin(Zlowin), .Zhighin(Zhighin), .HIin(HIin), .LOin(LOin),
      .IncPC(IncPC), .read(read), .operation(operation),
      .R_in(R_in), .R_out(R_out), .illegal(illegal), .halted(halted)
   );
   initial clock = 1'b0;
   always #5 clock = ~clock;
   always_comb obs = {PCout, ZLOout, ZHIout, MDRout, MARin, PCin, MDRin, IRin, Yin,
      Zlowin, Zhighin, HIin, LOin, IncPC, read, illegal, halted, operation, R_in, R_out};
   function automatic obs_t quiet();
      obs_t e;
      e = '0;
      e.op = cur_op;
      return e;
   endfunction
   task automatic cmp(input string tag, input obs_t e);
      n_checks++;
      assert (obs === e) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, 54'(obs), 54'(e));
      end
   endtask
   task automatic cyc(input string tag, input obs_t e);
      @(negedge clock);
      cmp(tag, e);
      @(posedge clock);
      #1;
   endtask
   // Entered during a T0 cycle; leaves the DUT in T0 again unless the op halts.
   task automatic exec_instr(input logic [31:0] ir, input int waits, input bit run_after, input bit abort);
      logic [4:0] opc;
      logic [3:0] ra, rb, rc;
      bit md, un, df;
      obs_t e;
      opc = ir[31:27];
      ra = ir[26:23];
      rb = ir[22:19];
      rc = ir[18:15];
      md = opc == 5'b01111 || opc == 5'b10000;
      un = opc == 5'b10001 || opc == 5'b10010;
      df = 0;
      foreach (LEGAL[i]) if (LEGAL[i] == opc) df = 1;
      IR = ir;
      run = 1'($urandom);
      mem_ready = 1'b0;
      e = quiet(); e.pc_out = 1; e.mar_in = 1; e.inc_pc = 1; e.zlow_in = 1;
      cyc("T0", e);
      for (int i = 0; i <= waits; i++) begin
         mem_ready = (i == waits);
         run = 1'($urandom);
         e = quiet(); e.zlo_out = 1; e.pc_in = 1; e.rd = 1; e.mdr_in = 1;
         cyc("T1", e);
      end
      mem_ready = 1'($urandom);
      e = quiet(); e.mdr_out = 1; e.ir_in = 1;
      cyc("T2", e);
      run = run_after;
      e = quiet();
      if (df) begin e.rout = 16'(1) << rb; e.y_in = 1; end
      else e.ill = 1;
      cyc("T3", e);
      cur_op = opc;
      if (opc == OP_HALT) begin
         run = 1'b1;
         for (int i = 0; i < 10; i++) begin
            mem_ready = 1'($urandom);
            e = quiet(); e.hlt = 1;
            cyc("HALT", e);
         end
      end else if (df && abort) begin
         clear = 1'b0;
         cur_op = '0;
         #1;
         cmp("CLEAR_IMMEDIATE", '0);
         @(negedge clock);
         cmp("CLEAR_HELD", '0);
         @(posedge clock);
         #1;
         clear = 1'b1;
         run = 1'b1;
         cyc("IDLE_AFTER_CLEAR", quiet());
      end else begin
         if (df) begin
            e = quiet(); e.rout = 16'(1) << (un ? rb : rc); e.zlow_in = 1; e.zhigh_in = md;
            cyc("T4", e);
            e = quiet(); e.zlo_out = 1;
            if (md) e.lo_in = 1;
            else e.rin = 16'(1) << ra;
            cyc("T5", e);
            if (md) begin
               e = quiet(); e.zhi_out = 1; e.hi_in = 1;
               cyc("T6", e);
            end
         end
         if (!run_after) begin
            for (int i = 0; i < 3; i++) cyc("IDLE_WAIT", quiet());
            run = 1'b1;
            cyc("IDLE_GO", quiet());
         end
      end
   endtask
   initial begin
      logic [4:0] opc;
      bit legal;
      clear = 1'b0;
      run = 1'b0;
      mem_ready = 1'b0;
      IR = '0;
      cur_op = '0;
      #2;
      cmp("RESET", '0);
      repeat (2) cyc("RESET_HOLD", quiet());
      clear = 1'b1;
      cyc("IDLE_RUN0", quiet());
      run = 1'b1;
      cyc("IDLE_GO", quiet());
      exec_instr(32'h5b320000, 0, 1, 0);
      exec_instr({OP_ADD, 4'd1, 4'd2, 4'd3, 15'd0}, 1, 1, 1);
      exec_instr(32'h7a320000, 3, 1, 0);
      exec_instr({5'b10001, 4'd15, 4'd9, 4'd2, 15'h1234}, 0, 1, 0);
      exec_instr({5'b10010, 4'd0, 4'd0, 4'd0, 15'd0}, 2, 1, 0);
      exec_instr({5'b10000, 4'd3, 4'd3, 4'd3, 15'd0}, 0, 1, 0);
      exec_instr(32'hf8000000, 0, 1, 0);
      exec_instr({OP_ADD, 4'd5, 4'd5, 4'd7, 15'd0}, 1, 0, 0);
      for (int k = 0; k < 30; k++) begin
         if ($urandom_range(0, 3) == 0) begin
            do begin
               opc = 5'($urandom);
               legal = 0;
               foreach (LEGAL[i]) if (LEGAL[i] == opc) legal = 1;
            end while (legal);
         end else opc = LEGAL[$urandom_range(0, 11)];
         exec_instr({opc, 27'($urandom)}, $urandom_range(0, 3), $urandom_range(0, 3) != 0,
            $urandom_range(0, 7) == 0);
      end
      exec_instr({OP_HALT, 27'($urandom)}, 1, 1, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
